// File: rtl/lfsr_sng_multi_pkg.sv
// Shared types and helpers for the multi-channel Galois LFSR stochastic number generator.
//   sng_state_t : stream engine states
//   TAPS_W*     : maximal-length Galois feedback masks for common widths
//   lfsr_step   : one Galois step (left shift, xor mask when MSB falls out)
//   rotl        : rotate-left within a w-bit field (channel views of a shared LFSR)
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sng_state_t;

  localparam logic [7:0]  TAPS_W8  = 8'h71;          // x^8+x^6+x^5+x^4+1
  localparam logic [11:0] TAPS_W12 = 12'h053;        // x^12+x^6+x^4+x+1
  localparam logic [15:0] TAPS_W16 = 16'h6801;       // x^16+x^14+x^13+x^11+1
  localparam logic [23:0] TAPS_W24 = 24'hC20001;     // x^24+x^23+x^22+x^17+1
  localparam logic [31:0] TAPS_W32 = 32'h0040_0007;  // x^32+x^22+x^2+x+1

  // Operates on a 32-bit container; bits above w are cleared on return.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] mask,
                                            input int unsigned w);
    logic [31:0] keep;
    logic [31:0] fb;
    keep = 32'hFFFF_FFFF >> (32 - w);
    fb   = (((s >> (w - 1)) & 32'h1) != 32'h0) ? mask : 32'h0;
    return ((s << 1) ^ fb) & keep;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned sh,
                                       input int unsigned w);
    logic [31:0]  keep;
    int unsigned  s;
    keep = 32'hFFFF_FFFF >> (32 - w);
    s    = sh % w;
    // x is zero above w, so the right shift by w (s == 0) contributes nothing
    return ((x << s) | ((x & keep) >> (w - s))) & keep;
  endfunction

endpackage

// File: rtl/lfsr_sng_multi_if.sv
// Handshake/data bundle for lfsr_sng_multi.
//   master (driver side): start, len, load, seed, value -> ; <- bit_out, valid, busy, done,
//                         countval, overflow
//   slave  (the SNG)    : the mirror image
interface lfsr_sng_multi_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2
);
  logic                           start;
  logic [WIDTH-1:0]               len;
  logic                           load;
  logic [NUM_CH-1:0][WIDTH-1:0]   seed;
  logic [NUM_CH-1:0][WIDTH-1:0]   value;
  logic [NUM_CH-1:0]              bit_out;
  logic                           valid;
  logic                           busy;
  logic                           done;
  logic [NUM_CH-1:0][WIDTH-1:0]   countval;
  logic [NUM_CH-1:0]              overflow;

  modport master (output start, len, load, seed, value,
                  input  bit_out, valid, busy, done, countval, overflow);
  modport slave  (input  start, len, load, seed, value,
                  output bit_out, valid, busy, done, countval, overflow);
endinterface

// File: rtl/lfsr_sng_multi_ch.sv
// One Galois LFSR channel: seed load with zero-seed substitution, step, and period-wrap detect.
//   clk, rst : clock, synchronous active-low reset
//   load     : take seed (all-zero seed replaced by DEFAULT_SEED); also becomes the stored seed
//   step     : advance one Galois step
//   seed     : seed to load
//   lfsr     : current state
//   hit      : the step just taken landed back on the stored seed
module lfsr_galois_ch import lfsr_pkg::*; #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAP_MASK     = 16'h6801,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hAAAA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] lfsr,
  output logic             hit
);
  logic [WIDTH-1:0] seed_q, seed_eff, nxt;
  logic             stepped_q;

  // all-zero is the lock-up state of an xor LFSR, never allow it in
  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
  assign nxt      = WIDTH'(lfsr_step(32'(lfsr), 32'(TAP_MASK), WIDTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr      <= DEFAULT_SEED;
      seed_q    <= DEFAULT_SEED;
      stepped_q <= 1'b0;
    end else if (load) begin
      lfsr      <= seed_eff;
      seed_q    <= seed_eff;
      stepped_q <= 1'b0;
    end else begin
      if (step) lfsr <= nxt;
      stepped_q <= step;
    end
  end

  // Qualified by "just stepped" so a held LFSR sitting on its seed yields a single pulse.
  assign hit = stepped_q && (lfsr == seed_q);
endmodule

// File: rtl/lfsr_sng_multi.sv
// Multi-channel Galois LFSR stochastic number generator with a start/len/done stream engine.
//   clk, rst : clock, synchronous active-low reset
//   bus      : lfsr_sng_multi_if slave -- start/len/load/seed/value in;
//              bit_out/valid/busy/done/countval/overflow out
// SHARED=0 gives each channel its own LFSR; SHARED=1 runs one LFSR (seed slice 0) and channel c
// sees it rotated left by c*(WIDTH/NUM_CH).
module lfsr_sng_multi import lfsr_pkg::*; #(
  parameter int               WIDTH        = 16,
  parameter int               NUM_CH       = 2,
  parameter logic [WIDTH-1:0] TAP_MASK     = 16'h6801,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hAAAA,
  parameter bit               SHARED       = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_sng_multi_if.slave    bus
);
  localparam int ROT = WIDTH / NUM_CH;

  sng_state_t                   state, state_nx;
  logic                         do_load, do_start, do_step;
  logic [WIDTH-1:0]             cnt;
  logic [NUM_CH-1:0][WIDTH-1:0] val_q, view, view_rst;
  logic [NUM_CH-1:0]            hit, cmp;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_load  = 1'b0;
    do_start = 1'b0;
    do_step  = 1'b0;
    case (state)
      IDLE: begin
        do_load = bus.load;
        if (bus.start) begin
          do_start = 1'b1;
          state_nx = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        do_step = 1'b1;
        if (cnt == WIDTH'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  if (SHARED) begin : g_shared
    logic [WIDTH-1:0] lfsr_s;
    logic             hit_s;
    lfsr_galois_ch #(.WIDTH(WIDTH), .TAP_MASK(TAP_MASK), .DEFAULT_SEED(DEFAULT_SEED)) u_ch (
      .clk(clk), .rst(rst), .load(do_load), .step(do_step),
      .seed(bus.seed[0]), .lfsr(lfsr_s), .hit(hit_s)
    );
    for (genvar c = 0; c < NUM_CH; c++) begin : g_view
      assign view[c]     = WIDTH'(rotl(32'(lfsr_s), c * ROT, WIDTH));
      assign view_rst[c] = WIDTH'(rotl(32'(DEFAULT_SEED), c * ROT, WIDTH));
      assign hit[c]      = hit_s;
    end
  end else begin : g_split
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      lfsr_galois_ch #(.WIDTH(WIDTH), .TAP_MASK(TAP_MASK), .DEFAULT_SEED(DEFAULT_SEED)) u_ch (
        .clk(clk), .rst(rst), .load(do_load), .step(do_step),
        .seed(bus.seed[c]), .lfsr(view[c]), .hit(hit[c])
      );
      assign view_rst[c] = DEFAULT_SEED;
    end
  end

  // compare uses the pre-step state: bit_out and countval describe the same LFSR value
  always_comb begin
    cmp = '0;
    for (int c = 0; c < NUM_CH; c++) cmp[c] = val_q[c] > view[c];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      val_q        <= '0;
      bus.valid    <= 1'b0;
      bus.bit_out  <= '0;
      bus.done     <= 1'b0;
      bus.overflow <= '0;
      bus.countval <= view_rst;
    end else begin
      if (do_start) begin
        cnt   <= bus.len;
        val_q <= bus.value;
      end else if (do_step) begin
        cnt <= cnt - WIDTH'(1);
      end
      bus.valid    <= do_step;
      bus.bit_out  <= do_step ? cmp : '0;
      bus.done     <= (state == DONE);
      bus.overflow <= hit;
      bus.countval <= view;
    end
  end

  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_lfsr_sng_multi.sv
module tb_lfsr_sng_multi;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  lfsr_sng_multi_if #(.WIDTH(16), .NUM_CH(2)) ifa ();
  lfsr_sng_multi_if #(.WIDTH(16), .NUM_CH(4)) ifb ();

  lfsr_sng_multi #(.WIDTH(16), .NUM_CH(2), .TAP_MASK(16'h6801), .DEFAULT_SEED(16'hAAAA),
                   .SHARED(1'b0)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  lfsr_sng_multi #(.WIDTH(16), .NUM_CH(4), .TAP_MASK(16'h6801), .DEFAULT_SEED(16'hAAAA),
                   .SHARED(1'b1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the LFSR as multiplication by x modulo P(x)=x^16+x^14+x^13+x^11+1.
  function automatic int unsigned m_next(input int unsigned v);
    int unsigned r;
    r = v * 2;
    if (r >= 32'h10000) r = (r - 32'h10000) ^ 32'h6801;
    return r;
  endfunction

  function automatic int unsigned m_rotl(input int unsigned v, input int unsigned s);
    return ((v << s) | (v >> (16 - s))) & 32'hFFFF;
  endfunction

  int unsigned m_lfsr[2];
  int unsigned m_seed[2];

  // One stream on dut_a. inject >= 0 pulses start+load (other seed) at that sampled cycle.
  task automatic stream(input bit ld, input logic [15:0] s0, input logic [15:0] s1,
                        input logic [15:0] ln, input logic [15:0] v0, input logic [15:0] v1,
                        input int inject, output int ones0, output int ones1,
                        output int eones0, output int eones1);
    logic [1:0]  exp_q[$];
    logic [15:0] vv[2];
    int          nvalid = 0, bad = 0, ovf0 = 0, ovf1 = 0, eovf0 = 0, eovf1 = 0;
    bit          seen_done = 1'b0;
    ones0 = 0; ones1 = 0; eones0 = 0; eones1 = 0;
    vv[0] = v0; vv[1] = v1;
    if (ld) begin
      m_lfsr[0] = (s0 == 16'h0) ? 32'hAAAA : 32'(s0);
      m_lfsr[1] = (s1 == 16'h0) ? 32'hAAAA : 32'(s1);
      m_seed    = m_lfsr;
    end
    for (int i = 0; i < int'(ln); i++) begin
      logic [1:0] b;
      for (int c = 0; c < 2; c++) begin
        b[c] = 32'(vv[c]) > m_lfsr[c];
        m_lfsr[c] = m_next(m_lfsr[c]);
      end
      exp_q.push_back(b);
      eones0 += int'(b[0]);
      eones1 += int'(b[1]);
      if (m_lfsr[0] == m_seed[0]) eovf0++;
      if (m_lfsr[1] == m_seed[1]) eovf1++;
    end

    @(negedge clk);
    ifa.load = ld; ifa.seed[0] = s0; ifa.seed[1] = s1;
    ifa.start = 1'b1; ifa.len = ln; ifa.value[0] = v0; ifa.value[1] = v1;
    @(negedge clk);
    ifa.load = 1'b0; ifa.start = 1'b0;
    chk("busy_after_start", ifa.busy, 1);

    for (int cyc = 0; cyc <= int'(ln) + 8; cyc++) begin
      if (cyc == inject + 1) begin ifa.start = 1'b0; ifa.load = 1'b0; end
      if (ifa.valid) begin
        if (nvalid < exp_q.size() && ifa.bit_out !== exp_q[nvalid]) bad++;
        ones0 += int'(ifa.bit_out[0]);
        ones1 += int'(ifa.bit_out[1]);
        nvalid++;
      end
      ovf0 += int'(ifa.overflow[0]);
      ovf1 += int'(ifa.overflow[1]);
      if (ifa.done) begin
        seen_done = 1'b1;
        chk("valid_low_at_done", ifa.valid, 0);
        chk("busy_low_at_done", ifa.busy, 0);
        chk("countval0_final", ifa.countval[0], m_lfsr[0]);
        chk("countval1_final", ifa.countval[1], m_lfsr[1]);
        break;
      end
      if (cyc == inject) begin
        ifa.start = 1'b1; ifa.load = 1'b1; ifa.len = 16'd5;
        ifa.seed[0] = 16'h1111; ifa.seed[1] = 16'h2222;
      end
      @(negedge clk);
    end
    ifa.start = 1'b0; ifa.load = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("valid_count", nvalid, int'(ln));
    chk("bit_mismatches", bad, 0);
    chk("overflow0_pulses", ovf0, eovf0);
    chk("overflow1_pulses", ovf1, eovf1);
    @(negedge clk);
    chk("done_one_cycle", ifa.done, 0);
  endtask

  typedef struct {
    bit          ld;
    logic [15:0] s0, s1, ln, v0, v1;
    int          ones0, ones1;
    logic [15:0] cv0, cv1;
  } vec_t;

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   o0, o1, e0, e1;

    // hand-derived: x^k shifting, 8000 -> 6801 -> D002, AAAA -> 3D55 -> 7AAA, FFFF -> 97FF -> 47FF
    vecs[0] = '{1'b1, 16'h0001, 16'h0100, 16'd4, 16'h8000, 16'h0300, 4, 2, 16'h0010, 16'h1000};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16'd3, 16'h0000, 16'hFFFF, 0, 3, 16'h0080, 16'h8000};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'd2, 16'hFFFF, 16'h8001, 2, 2, 16'h0200, 16'hD002};
    vecs[3] = '{1'b1, 16'h0000, 16'hFFFF, 16'd2, 16'hAAAB, 16'hFFFF, 2, 1, 16'h7AAA, 16'h47FF};
    vecs[4] = '{1'b1, 16'h0000, 16'h0001, 16'd0, 16'hFFFF, 16'hFFFF, 0, 0, 16'hAAAA, 16'h0001};

    rst_a = 1'b0; rst_b = 1'b0;
    ifa.start = 0; ifa.load = 0; ifa.len = '0; ifa.seed = '0; ifa.value = '0;
    ifb.start = 0; ifb.load = 0; ifb.len = '0; ifb.seed = '0; ifb.value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_countval0", ifa.countval[0], 16'hAAAA);
    chk("rst_countval1", ifa.countval[1], 16'hAAAA);
    chk("rst_bit_out", ifa.bit_out, 0);
    chk("rst_valid", ifa.valid, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_overflow", ifa.overflow, 0);
    for (int c = 0; c < 4; c++) chk("rst_b_countval", ifb.countval[c], m_rotl(32'hAAAA, 4 * c));
    rst_a = 1'b1; rst_b = 1'b1;
    m_lfsr[0] = 32'hAAAA; m_lfsr[1] = 32'hAAAA; m_seed = m_lfsr;

    for (int i = 0; i < 5; i++) begin
      stream(vecs[i].ld, vecs[i].s0, vecs[i].s1, vecs[i].ln, vecs[i].v0, vecs[i].v1, -1,
             o0, o1, e0, e1);
      chk("vec_ones0", o0, vecs[i].ones0);
      chk("vec_ones1", o1, vecs[i].ones1);
      chk("vec_countval0", ifa.countval[0], vecs[i].cv0);
      chk("vec_countval1", ifa.countval[1], vecs[i].cv1);
    end

    // start/load while RUN and while DONE must be ignored
    stream(1'b0, 16'h0, 16'h0, 16'd6, 16'h5555, 16'hAAAA, 2, o0, o1, e0, e1);
    stream(1'b0, 16'h0, 16'h0, 16'd3, 16'h7000, 16'h1000, 3, o0, o1, e0, e1);

    // full period: every nonzero state visited once, one wrap back onto the seed
    stream(1'b1, 16'h0001, 16'hACE1, 16'hFFFF, 16'h4000, 16'h8000, -1, o0, o1, e0, e1);
    chk("fp_ones0", o0, e0);
    chk("fp_ones1", o1, e1);

    for (int i = 0; i < 25; i++) begin
      logic [15:0] s0, s1, v0, v1, ln;
      int          inj;
      s0 = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      s1 = 16'($urandom);
      v0 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      v1 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      ln = 16'($urandom_range(0, 40));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(ln))) : -1;
      stream(1'($urandom_range(0, 1)), s0, s1, ln, v0, v1, inj, o0, o1, e0, e1);
    end

    // shared LFSR, rotated channel views, then reset in mid-stream
    begin
      int unsigned mb;
      int unsigned r;
      logic [15:0] vb[4];
      int          nv = 0, bad = 0, abort_bad = 0;
      mb = 32'h1234;
      vb[0] = 16'h8000; vb[1] = 16'h4000; vb[2] = 16'hFFFF; vb[3] = 16'h0000;
      @(negedge clk);
      ifb.load = 1'b1; ifb.seed = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234};
      ifb.start = 1'b1; ifb.len = 16'd20;
      ifb.value = {vb[3], vb[2], vb[1], vb[0]};
      @(negedge clk);
      ifb.load = 1'b0; ifb.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (ifb.valid) begin
          for (int c = 0; c < 4; c++) begin
            r = m_rotl(mb, 4 * c);
            if (ifb.countval[c] !== r[15:0]) bad++;
            if (ifb.bit_out[c] !== (32'(vb[c]) > r)) bad++;
          end
          nv++;
          mb = m_next(mb);
        end
        @(negedge clk);
      end
      chk("shared_valid_cycles", nv, 5);
      chk("shared_mismatches", bad, 0);
      rst_b = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (ifb.done !== 1'b0 || ifb.valid !== 1'b0 || ifb.busy !== 1'b0) abort_bad++;
      end
      rst_b = 1'b1;
      repeat (25) begin
        @(negedge clk);
        if (ifb.done !== 1'b0 || ifb.valid !== 1'b0 || ifb.busy !== 1'b0) abort_bad++;
      end
      chk("abort_no_done", abort_bad, 0);
      for (int c = 0; c < 4; c++) chk("abort_countval", ifb.countval[c], m_rotl(32'hAAAA, 4 * c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
